// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and sizing helpers for the restoring divider
package div_pkg;

  // Controller states: waiting for a command, iterating, presenting the result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Default operand width and the matching iteration-counter width
  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int CNT_W_DEFAULT      = $clog2(DATA_WIDTH_DEFAULT);

  // Counter width for an arbitrary operand width; never narrower than one bit
  function automatic int cnt_width(input int data_width);
    return (data_width > 2) ? $clog2(data_width) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring division iteration
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] partial,
  input  logic                  next_bit,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] new_partial,
  output logic                  quotient_bit
);

  // The shifted remainder can reach 2*divisor-1, so it needs one extra bit
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH-1:0] diff;

  assign shifted = {partial, next_bit};

  // When the subtraction is taken the true difference is below divisor,
  // so the low DATA_WIDTH bits of the shifted value carry it exactly
  assign diff = shifted[DATA_WIDTH-1:0] - divisor;

  // Compare on DATA_WIDTH+1 bits so a set top bit of shifted is honoured
  assign quotient_bit = (shifted >= {1'b0, divisor});
  assign new_partial  = quotient_bit ? diff : shifted[DATA_WIDTH-1:0];

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - multi-cycle unsigned restoring divider with start/complete handshake
module divider
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  busy,
  output logic                  complete,
  output logic                  div_by_zero
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);

  div_state_t            state;
  logic [CNT_W-1:0]      cnt;
  // Dividend bits leave at the top while quotient bits enter at the bottom;
  // after DATA_WIDTH shifts the register holds the complete quotient
  logic [DATA_WIDTH-1:0] dq_shift;
  logic [DATA_WIDTH-1:0] divisor_q;
  logic [DATA_WIDTH-1:0] partial_q;

  logic [DATA_WIDTH-1:0] step_partial;
  logic                  step_qbit;

  div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .partial     (partial_q),
    .next_bit    (dq_shift[DATA_WIDTH-1]),
    .divisor     (divisor_q),
    .new_partial (step_partial),
    .quotient_bit(step_qbit)
  );

  // Control FSM plus datapath registers and registered result outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      dq_shift    <= '0;
      divisor_q   <= '0;
      partial_q   <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      complete    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          complete <= 1'b0;
          if (start) begin
            dq_shift    <= dividend;
            divisor_q   <= divisor;
            partial_q   <= '0;
            cnt         <= CNT_W'(DATA_WIDTH - 1);
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              // No iterations needed: publish the saturated result at once
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              complete    <= 1'b1;
              busy        <= 1'b0;
              state       <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end

        RUN: begin
          partial_q <= step_partial;
          dq_shift  <= {dq_shift[DATA_WIDTH-2:0], step_qbit};
          cnt       <= cnt - 1'b1;
          if (cnt == '0) begin
            // Final iteration: results appear only here, never mid-operation
            quotient  <= {dq_shift[DATA_WIDTH-2:0], step_qbit};
            remainder <= step_partial;
            complete  <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end

        DONE: begin
          // start is deliberately not looked at here
          complete <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          complete <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
